lsu_mem_stage: RTL and testbench

//  Load/store unit sitting between the EX/MEM pipeline register and the word-addressed data memory.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 42 ++++
 rtl/lsu_mem_stage.sv | 118 +++++++++++
 tb/tb_lsu_mem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, fault codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_MIS  = 2'b01;
  localparam logic [1:0] FLT_OOR  = 2'b10;
  localparam logic [1:0] FLT_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load data from a memory word and merges
// sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [31:0]        shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    shifted = ld_word >> {off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (funct3)
      F3_B:    ld_data = 32'(lane_b);
      F3_H:    ld_data = 32'(lane_h);
      F3_BU:   ld_data = {24'b0, shifted[7:0]};
      F3_HU:   ld_data = {16'b0, shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  // Untouched lanes keep the just-read bytes so the full-word write is harmless.
  always_comb begin
    st_data = st_word;
    case (funct3)
      F3_B:    st_data[{off, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: st_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit between EX/MEM and a word-addressed data memory without byte
// enables; sub-word stores are done as read-modify-write.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Priority: illegal funct3 > misaligned > out of range.
  function automatic logic [1:0] fault_of(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    logic ill, mis, oor;
    if (we) ill = !(f3 inside {F3_B, F3_H, F3_W});
    else    ill = f3 inside {3'b011, 3'b110, 3'b111};
    mis = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oor = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
    if (ill)      return FLT_ILL;
    else if (mis) return FLT_MIS;
    else if (oor) return FLT_OOR;
    else          return FLT_NONE;
  endfunction

  state_t      state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic [1:0]  resp_fault_q;
  logic [1:0]  req_fault;
  logic [31:0] ld_data;
  logic [31:0] st_data;

  assign req_fault = fault_of(req_we, req_funct3, req_addr);

  lsu_align u_align (
    .ld_word (mem_rdata),
    .st_word (old_q),
    .wdata   (wdata_q),
    .off     (addr_q[1:0]),
    .funct3  (f3_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_fault_q <= FLT_NONE;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q         <= req_funct3;
          addr_q       <= req_addr;
          wdata_q      <= req_wdata;
          resp_data_q  <= '0;
          resp_rd_q    <= req_we ? 5'd0 : req_rd;
          resp_fault_q <= req_fault;
          if (req_fault != FLT_NONE)  state <= RESP;
          else if (!req_we)           state <= LOAD;
          else if (req_funct3 == F3_W) state <= STORE;
          else                        state <= RMW_RD;
        end
        LOAD: begin
          resp_data_q <= ld_data;
          state       <= RESP;
        end
        STORE:  state <= RESP;
        RMW_RD: begin
          old_q <= mem_rdata;
          state <= RMW_WR;
        end
        RMW_WR: state <= RESP;
        RESP:   if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = resp_valid ? resp_data_q  : 32'd0;
  assign resp_rd    = resp_valid ? resp_rd_q    : 5'd0;
  assign resp_fault = resp_valid ? resp_fault_q : FLT_NONE;
  assign mem_read   = (state == LOAD)  || (state == RMW_RD);
  assign mem_write  = (state == STORE) || (state == RMW_WR);
  assign mem_addr   = (state != IDLE) ? {2'b00, addr_q[31:2]} : 32'd0;
  assign mem_wdata  = (state == STORE)  ? wdata_q :
                      (state == RMW_WR) ? st_data : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus random requests checked against a byte-level memory model.
module tb_lsu_mem_stage;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_fault;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  assign mem_rdata = (mem_addr < MEM_WORDS) ? mem[mem_addr[5:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_write && mem_addr < MEM_WORDS) mem[mem_addr[5:0]] <= mem_wdata;

  int          n_wr, n_rd;
  logic [31:0] last_wdata, last_waddr, last_raddr;
  always @(negedge clk) begin
    if (mem_write) begin n_wr++; last_wdata = mem_wdata; last_waddr = mem_addr; end
    if (mem_read)  begin n_rd++; last_raddr = mem_addr; end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[7:2]] >> (8 * a[1:0]);
    return w[7:0];
  endfunction

  // Architectural meaning of an RV32I load/store on a byte-addressed memory.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       output logic [1:0] flt, output logic [31:0] data, output logic [4:0] erd,
                       output int lat, output int reads, output int writes);
    int size;
    bit illegal;
    longint unsigned v;
    logic [31:0] a;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    flt = 2'd0; data = 32'd0; erd = we ? 5'd0 : rd; reads = 0; writes = 0; lat = 1;
    if (illegal)                         flt = 2'd3;
    else if ((addr % size) != 0)         flt = 2'd1;
    else if ((addr / 4) >= MEM_WORDS)    flt = 2'd2;
    if (flt != 2'd0) return;
    if (!we) begin
      lat = 2; reads = 1; v = 0;
      for (int i = 0; i < size; i++) begin
        a = addr + i;
        v |= longint'(ref_byte(a)) << (8 * i);
      end
      if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 1);
      data = v[31:0];
    end else begin
      writes = 1; reads = (size < 4) ? 1 : 0; lat = (size < 4) ? 3 : 2;
      for (int i = 0; i < size; i++) begin
        a = addr + i;
        ref_mem[a[7:2]][8*a[1:0] +: 8] = wdata[8*i +: 8];
      end
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int hold, output logic [31:0] obs);
    logic [1:0]  e_flt;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    int e_lat, e_rd_n, e_wr_n, lat;
    bit got;
    logic [31:0] held;
    model(we, f3, addr, wdata, rd, e_flt, e_data, e_rd, e_lat, e_rd_n, e_wr_n);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    n_wr = 0; n_rd = 0;
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      @(negedge clk); #1;
      lat++;
      if (resp_valid) got = 1;
    end
    if (!got) lat = 99;
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".data"}, resp_data, e_data);
    check({tag, ".rd"}, 32'(resp_rd), 32'(e_rd));
    check({tag, ".fault"}, 32'(resp_fault), 32'(e_flt));
    obs = resp_data;
    held = resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_data"}, resp_data, held);
      check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    check({tag, ".idle_after"}, {30'd0, req_ready, resp_valid}, 32'b10);
    check({tag, ".n_reads"}, 32'(n_rd), 32'(e_rd_n));
    check({tag, ".n_writes"}, 32'(n_wr), 32'(e_wr_n));
    if (e_rd_n != 0) check({tag, ".raddr"}, last_raddr, addr >> 2);
    if (e_wr_n != 0) begin
      check({tag, ".waddr"}, last_waddr, addr >> 2);
      check({tag, ".wdata"}, last_wdata, ref_mem[addr[7:2]]);
      check({tag, ".mem"}, mem[addr[7:2]], ref_mem[addr[7:2]]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          kind;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[1] = 32'h0000_0054;
    mem[3] = 32'h8000_F03B;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];

    repeat (2) @(negedge clk);
    #1;
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.outputs", {25'd0, resp_valid, resp_fault, resp_rd == 5'd0, mem_read, mem_write},
          32'b0000100);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.resp_data", resp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_req("lw_4", 1'b0, 3'b010, 32'h4, 32'h0, 5'd7, 0, d);
    check("lw_4.const", d, 32'h0000_0054);
    run_req("lb_f", 1'b0, 3'b000, 32'hF, 32'h0, 5'd8, 0, d);
    check("lb_f.const", d, 32'hFFFF_FF80);
    run_req("lbu_f", 1'b0, 3'b100, 32'hF, 32'h0, 5'd9, 0, d);
    check("lbu_f.const", d, 32'h0000_0080);
    run_req("lh_c", 1'b0, 3'b001, 32'hC, 32'h0, 5'd10, 0, d);
    check("lh_c.const", d, 32'hFFFF_F03B);
    run_req("sb_d", 1'b1, 3'b000, 32'hD, 32'h1234_56AA, 5'd11, 0, d);
    check("sb_d.const", last_wdata, 32'h8000_AA3B);
    run_req("lw_6_mis", 1'b0, 3'b010, 32'h6, 32'h0, 5'd12, 0, d);
    run_req("sw_100_oor", 1'b1, 3'b010, 32'h100, 32'hCAFE_F00D, 5'd13, 0, d);
    run_req("ld_011_ill", 1'b0, 3'b011, 32'h8, 32'h0, 5'd14, 0, d);
    run_req("lw_backpressure", 1'b0, 3'b010, 32'h4, 32'h0, 5'd15, 4, d);

    // Reset while the RMW read is in flight.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'hD;
    req_wdata = 32'h0000_0055; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_wr = 0;
    @(negedge clk); #1;
    check("rst_mid.in_rmw_rd", {30'd0, mem_read, mem_write}, 32'b10);
    reset = 1'b1;
    #1;
    check("rst_mid.req_ready", 32'(req_ready), 32'd1);
    check("rst_mid.quiet", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("rst_mid.no_resp", 32'(resp_valid), 32'd0);
    end
    check("rst_mid.no_write", 32'(n_wr), 32'd0);
    check("rst_mid.mem_kept", mem[3], ref_mem[3]);
    check("rst_mid.req_ready_after", 32'(req_ready), 32'd1);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 7);
      r_we = 1'($urandom);
      r_f3 = 3'($urandom);
      if (kind < 6)       r_addr = $urandom_range(0, 4 * MEM_WORDS - 1);
      else if (kind == 6) r_addr = 4 * MEM_WORDS + $urandom_range(0, 64);
      else                r_addr = $urandom;
      run_req($sformatf("rand%0d", n), r_we, r_f3, r_addr, $urandom, 5'($urandom),
              $urandom_range(0, 2), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
